// File: rtl/div_if.sv
// Divider request/response bundle between the execute-stage ALU and the divider.
//   signed_div  ALU -> div  1 = signed divide, 0 = unsigned
//   opdata1     ALU -> div  dividend
//   opdata2     ALU -> div  divisor
//   start       ALU -> div  request, held until ready is seen
//   annul       ALU -> div  abort any in-flight divide
//   result      div -> ALU  {remainder, quotient}
//   ready       div -> ALU  result valid
interface div_if #(
    parameter int unsigned WIDTH = 32
);
    logic               signed_div;
    logic [WIDTH-1:0]   opdata1;
    logic [WIDTH-1:0]   opdata2;
    logic               start;
    logic               annul;
    logic [2*WIDTH-1:0] result;
    logic               ready;

    modport master (
        output signed_div, opdata1, opdata2, start, annul,
        input  result, ready
    );

    modport slave (
        input  signed_div, opdata1, opdata2, start, annul,
        output result, ready
    );
endinterface

// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   div_if slave: operands/start/annul in, {remainder, quotient} result and ready out
// A non-zero divide takes WIDTH cycles from the start edge; divide-by-zero reports 0 after two.
module div_radix2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic   clk,
    input  logic   rst,
    div_if.slave   bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StDivZero, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;   // dividend shifts out, quotient bits shift in
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               sdiv_q, sdiv_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    // One restoring step; compare/subtract on WIDTH+1 bits so the shifted-in MSB is kept.
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               a_neg;
    logic               b_neg;

    always_comb begin
        rem_sh  = {rem_q, dvd_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, dsr_q};
        q_bit   = ~diff[WIDTH];
        rem_nxt = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nxt = {dvd_q[WIDTH-2:0], q_bit};
        quo_fix = (sdiv_q & (sign_a_q ^ sign_b_q)) ? -quo_nxt : quo_nxt;
        rem_fix = (sdiv_q & sign_a_q) ? -rem_nxt : rem_nxt;
        a_neg   = bus.signed_div & bus.opdata1[WIDTH-1];
        b_neg   = bus.signed_div & bus.opdata2[WIDTH-1];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        rem_d    = rem_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        sdiv_d   = sdiv_q;
        result_d = result_q;
        ready_d  = ready_q;

        unique case (state_q)
            StIdle: begin
                ready_d = 1'b0;
                cnt_d   = '0;
                if (bus.start) begin
                    if (bus.opdata2 == '0) begin
                        state_d = StDivZero;
                    end else begin
                        // 0x80000000 negates to itself and is then used as unsigned
                        dvd_d    = a_neg ? -bus.opdata1 : bus.opdata1;
                        dsr_d    = b_neg ? -bus.opdata2 : bus.opdata2;
                        sign_a_d = a_neg;
                        sign_b_d = b_neg;
                        sdiv_d   = bus.signed_div;
                        rem_d    = '0;
                        state_d  = StRun;
                    end
                end
            end
            StDivZero: begin
                // Zero result posts on the second edge after start
                if (cnt_q == CntW'(1)) begin
                    result_d = '0;
                    ready_d  = 1'b1;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRun: begin
                rem_d = rem_nxt;
                dvd_d = quo_nxt;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (!bus.start) begin
                    ready_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (bus.annul) begin
            state_d  = StIdle;
            ready_d  = 1'b0;
            result_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            sdiv_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            rem_q    <= rem_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            sdiv_q   <= sdiv_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.result = result_q;
    assign bus.ready  = ready_q;
endmodule

// File: tb/tb_div_radix2.sv
// Self-checking bench for div_radix2: directed divides, divide-by-zero, annul, reset mid-run.
module tb_div_radix2;
    localparam int unsigned WIDTH = 32;

    logic clk;
    logic rst;

    div_if #(.WIDTH(WIDTH)) bus ();

    div_radix2 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests;
    int          n_fail;
    bit          chk_en;
    logic        exp_ready;
    logic [63:0] exp_result;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer division, truncating toward zero, remainder takes dividend sign.
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb, q, r;
        logic [31:0]        uq, ur;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    // Every cycle: outputs must match the expected timeline maintained by the stimulus.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", {63'd0, bus.ready}, {63'd0, exp_ready});
            check("result", bus.result, exp_result);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input bit early, input bit scramble, input logic [63:0] lit,
                         input string name);
        int          lat;
        logic [63:0] res;
        res = model(sgn, a, b);
        lat = (b == 32'd0) ? 2 : int'(WIDTH);
        bus.signed_div = sgn;
        bus.opdata1    = a;
        bus.opdata2    = b;
        bus.start      = 1'b1;
        tick();                             // start sampled here
        if (early) bus.start = 1'b0;
        for (int i = 1; i < lat; i++) begin
            if (scramble && i == 5) begin
                bus.opdata1    = ~a;
                bus.opdata2    = b + 32'd3;
                bus.signed_div = ~sgn;
            end
            tick();
        end
        tick();
        exp_ready  = 1'b1;
        exp_result = res;
        check(name, bus.result, lit);
        if (!early) begin
            tick();
            tick();
            bus.start = 1'b0;
        end
        tick();
        exp_ready = 1'b0;
    endtask

    task automatic abort_run(input logic [31:0] a, input logic [31:0] b, input int cycles,
                             input bit use_rst);
        bus.signed_div = 1'b0;
        bus.opdata1    = a;
        bus.opdata2    = b;
        bus.start      = 1'b1;
        tick();
        repeat (cycles) tick();
        bus.start = 1'b0;
        if (use_rst) rst = 1'b1;
        else bus.annul = 1'b1;
        tick();
        rst        = 1'b0;
        bus.annul  = 1'b0;
        exp_ready  = 1'b0;
        exp_result = 64'd0;
        check(use_rst ? "rst_clears" : "annul_clears", bus.result, 64'd0);
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        chk_en         = 1'b0;
        exp_ready      = 1'b0;
        exp_result     = 64'd0;
        rst            = 1'b1;
        bus.signed_div = 1'b0;
        bus.opdata1    = '0;
        bus.opdata2    = '0;
        bus.start      = 1'b0;
        bus.annul      = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_result", bus.result, 64'd0);
        check("reset_ready", {63'd0, bus.ready}, 64'd0);

        do_op(1'b0, 32'd100, 32'd7, 1'b0, 1'b0, {32'd2, 32'd14}, "divu_100_7");
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0,
              {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_m7_2");
        do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, {32'd1, 32'hFFFF_FFFD}, "div_7_m2");
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0,
              {32'h0, 32'h8000_0000}, "div_min_m1");
        do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, {32'h0, 32'hFFFF_FFFF}, "divu_max_1");
        do_op(1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 64'd0, "divu_by_zero");
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, {32'd0, 32'd1}, "divu_max_max");
        do_op(1'b1, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0, 64'd0, "div_by_zero");
        do_op(1'b0, 32'd3, 32'd5, 1'b0, 1'b0, {32'd3, 32'd0}, "divu_3_5");

        abort_run(32'd1234, 32'd5, 10, 1'b0);
        tick();
        do_op(1'b0, 32'd1000, 32'd33, 1'b0, 1'b0, {32'd10, 32'd30}, "after_annul");

        abort_run(32'd999, 32'd4, 20, 1'b1);
        tick();
        do_op(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b1,
              {32'hFFFF_FFFE, 32'hFFFF_FFF2}, "operands_frozen");

        // start and annul on the same idle edge: no divide may begin
        do_op(1'b0, 32'd50, 32'd6, 1'b0, 1'b0, {32'd2, 32'd8}, "divu_50_6");
        bus.opdata1 = 32'd77;
        bus.opdata2 = 32'd3;
        bus.start   = 1'b1;
        bus.annul   = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.annul  = 1'b0;
        exp_result = 64'd0;
        repeat (40) tick();

        // start dropped right after sampling: the run completes, ready shows for one cycle
        do_op(1'b0, 32'h1234_5678, 32'h100, 1'b1, 1'b0, {32'h78, 32'h0012_3456}, "early_drop");
        repeat (3) tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
